// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioner.
// State encoding, default cycle counts and the press counter width.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } btn_state_t;

    localparam int DB_CYCLES_DEF     = 16;
    localparam int HOLD_CYCLES_DEF   = 256;
    localparam int REPEAT_CYCLES_DEF = 64;
    localparam int PRESS_CNT_W       = 8;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input.
// Both flops clear to 0 on synchronous active-high reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw pin through two flops to settle metastability.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Synchronise, debounce and pulse-encode the puzzle push-button.
// Define BTN_AUTOREPEAT_EN to add repeated presses while held.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn,
    output logic                   btn_level,
    output logic                   btn_press,
    output logic                   btn_release,
    output logic [PRESS_CNT_W-1:0] press_cnt
);

    localparam int DB_W = cnt_w(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    if (DB_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
        $error("btn_conditioner: cycle counts out of range");
    end

    btn_state_t      state;
    logic [DB_W-1:0] db_cnt;
    logic            btn_s;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q   (btn_s)
    );

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                             HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RPT_W = cnt_w(RPT_MAX);
    localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;
    logic             rpt_fire;

    // A repeat only fires while the button is still seen held.
    assign rpt_fire = (state == HELD) && btn_s &&
                      (rpt_cnt == (rpt_first ? HOLD_LAST : RPT_LAST));

    // Repeat timer: runs in HELD, frozen in RELEASE_DB, cleared elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (state == HELD) begin
            if (btn_s) begin
                if (rpt_fire) begin
                    rpt_cnt   <= '0;
                    rpt_first <= 1'b0;
                end else begin
                    rpt_cnt <= rpt_cnt + RPT_W'(1);
                end
            end
        end else if (state != RELEASE_DB) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end
    end
`endif

    // Debounce FSM with registered level and press/release pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            db_cnt      <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (btn_s) begin
                        state  <= PRESS_DB;
                        db_cnt <= DB_W'(1);
                    end else begin
                        db_cnt <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!btn_s) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= HELD;
                        db_cnt    <= '0;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state  <= RELEASE_DB;
                        db_cnt <= DB_W'(1);
                    end else begin
                        db_cnt <= '0;
`ifdef BTN_AUTOREPEAT_EN
                        btn_press <= rpt_fire;
`endif
                    end
                end
                RELEASE_DB: begin
                    if (btn_s) begin
                        state  <= HELD;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= IDLE;
                        db_cnt      <= '0;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    db_cnt <= '0;
                end
            endcase
        end
    end

    // Count every press pulse, wrapping naturally at the counter width.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_cnt <= '0;
        end else if (btn_press) begin
            press_cnt <= press_cnt + PRESS_CNT_W'(1);
        end
    end

endmodule
